// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and transfer direction codes.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic APB_RD = 1'b0;
  localparam logic APB_WR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter. Flags the cycle in which the slave has had
// TIMEOUT access cycles without acknowledging. TIMEOUT = 0 never expires.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  // Index of the last allowed ACCESS cycle (counter starts at 0 in the first one).
  localparam logic [15:0] LP_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  // Counter: cleared on entry to ACCESS, increments while waiting, saturates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 16'd0;
    end else if (i_clear) begin
      r_cnt <= 16'd0;
    end else if (i_en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_cnt == LP_LAST);

endmodule

// File: rtl/apb_initiator.sv
// APB requester: one command at a time in, one APB transfer out, one
// response back. All APB and response outputs come straight from flops.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rw,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      apb_psel,
  output logic                      apb_rw,
  output logic [ADDR_WIDTH-1:0]     apb_addr,
  output logic                      apb_enab,
  output logic [APB_DATA_WIDTH-1:0] apb_datai,
  input  logic [APB_DATA_WIDTH-1:0] apb_datao,
  input  logic                      apb_ack
);

  apb_state_t                r_state, w_state_nxt;
  logic                      r_psel,  w_psel_nxt;
  logic                      r_enab,  w_enab_nxt;
  logic                      r_rw,    w_rw_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr,  w_addr_nxt;
  logic [APB_DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                      r_rvld,  w_rvld_nxt;
  logic [APB_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                      r_err,   w_err_nxt;
  logic                      w_expired;
  logic                      w_cnt_clr;
  logic                      w_cnt_en;

  // Counter restarts on the SETUP->ACCESS edge and only runs while still waiting.
  assign w_cnt_clr = (r_state == S_SETUP);
  assign w_cnt_en  = (r_state == S_ACCESS) && !apb_ack && !w_expired;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .resetn    (resetn),
    .i_clear   (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  // State and output registers; reset drops psel/enab and any pending response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_psel  <= 1'b0;
      r_enab  <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rvld  <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_psel  <= w_psel_nxt;
      r_enab  <= w_enab_nxt;
      r_rw    <= w_rw_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rvld  <= w_rvld_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a phase moves on.
  always_comb begin
    w_state_nxt = r_state;
    w_psel_nxt  = r_psel;
    w_enab_nxt  = r_enab;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rvld_nxt  = r_rvld;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_rw_nxt    = cmd_rw;
          w_addr_nxt  = cmd_addr;
          w_wdata_nxt = cmd_wdata;
          w_psel_nxt  = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_enab_nxt  = 1'b1;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // Ack takes priority over a timeout firing in the same cycle.
        if (apb_ack) begin
          w_psel_nxt  = 1'b0;
          w_enab_nxt  = 1'b0;
          w_rdata_nxt = (r_rw == APB_RD) ? apb_datao : '0;
          w_err_nxt   = 1'b0;
          w_rvld_nxt  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_expired) begin
          w_psel_nxt  = 1'b0;
          w_enab_nxt  = 1'b0;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_rvld_nxt  = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rvld_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign apb_psel  = r_psel;
  assign apb_enab  = r_enab;
  assign apb_rw    = r_rw;
  assign apb_addr  = r_addr;
  assign apb_datai = r_wdata;
  assign rsp_valid = r_rvld;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator with a programmable-wait APB slave model.
module tb_apb_initiator;

  localparam int TO = 8;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        apb_psel;
  logic        apb_rw;
  logic [31:0] apb_addr;
  logic        apb_enab;
  logic [31:0] apb_datai;
  logic [31:0] apb_datao;
  logic        apb_ack;

  int n_total = 0;
  int n_bad   = 0;

  // Slave model controls (written by the stimulus, read by the slave process).
  int          slv_wait  = 0;          // ack in ACCESS cycle index slv_wait; -1 = never
  logic [31:0] slv_rdata = 32'h0;
  logic [31:0] mon_addr  = 32'h0;

  // Monitor accumulators (written only by the slave/monitor process).
  int psel_tot = 0;
  int enab_tot = 0;
  int enab_wr  = 0;
  int addr_bad = 0;
  int acc_cyc  = 0;

  apb_initiator #(
    .ADDR_WIDTH     (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT        (TO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb_psel  (apb_psel),
    .apb_rw    (apb_rw),
    .apb_addr  (apb_addr),
    .apb_enab  (apb_enab),
    .apb_datai (apb_datai),
    .apb_datao (apb_datao),
    .apb_ack   (apb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave + bus monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (apb_psel === 1'b1) psel_tot++;
    if (apb_psel === 1'b1 && apb_enab === 1'b1) begin
      enab_tot++;
      if (apb_rw === 1'b1) enab_wr++;
      if (apb_addr !== mon_addr) addr_bad++;
      apb_ack   = (slv_wait >= 0) && (acc_cyc == slv_wait);
      apb_datao = slv_rdata;
      acc_cyc++;
    end else begin
      apb_ack   = 1'b0;
      apb_datao = slv_rdata;
      acc_cyc   = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until rsp_valid is seen; bounded so a dead DUT still ends.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // Present a command in IDLE, let it be accepted, then wait for the response.
  task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d, output int lat);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    mon_addr  = a;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    wait_rsp(lat);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int lat, p0, e0, w0, a0, stale;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_psel",   32'(apb_psel),  32'd0);
    check("rst_enab",   32'(apb_enab),  32'd0);
    check("rst_rw",     32'(apb_rw),    32'd0);
    check("rst_addr",   apb_addr,       32'h0);
    check("rst_datai",  apb_datai,      32'h0);
    check("rst_rvalid", 32'(rsp_valid), 32'd0);
    check("rst_rdata",  rsp_rdata,      32'h0);
    check("rst_err",    32'(rsp_err),   32'd0);
    check("rst_cready", 32'(cmd_ready), 32'd1);
    resetn = 1'b1;
    tick();

    // Write, zero wait states; slave drives nonzero read data that must be ignored
    slv_wait = 0; slv_rdata = 32'h1234_5678;
    p0 = psel_tot; e0 = enab_tot; w0 = enab_wr; a0 = addr_bad;
    send(1'b1, 32'h0000_0010, 32'h0000_000A, lat);
    check("wr_latency",  32'(lat),            32'd2);
    check("wr_psel_cyc", 32'(psel_tot - p0),  32'd2);
    check("wr_enab_cyc", 32'(enab_tot - e0),  32'd1);
    check("wr_enab_rw",  32'(enab_wr - w0),   32'd1);
    check("wr_addr",     32'(addr_bad - a0),  32'd0);
    check("wr_datai",    apb_datai,           32'h0000_000A);
    check("wr_rdata",    rsp_rdata,           32'h0);
    check("wr_err",      32'(rsp_err),        32'd0);
    check("wr_psel_off", 32'(apb_psel),       32'd0);
    check("wr_cready",   32'(cmd_ready),      32'd0);
    take_rsp();
    check("wr_rvld_off", 32'(rsp_valid),      32'd0);

    // Read, three wait states
    slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
    e0 = enab_tot; w0 = enab_wr; a0 = addr_bad;
    send(1'b0, 32'h0000_0024, 32'h0, lat);
    check("rd3_latency", 32'(lat),           32'd5);
    check("rd3_enab",    32'(enab_tot - e0), 32'd4);
    check("rd3_enab_rw", 32'(enab_wr - w0),  32'd0);
    check("rd3_addr",    32'(addr_bad - a0), 32'd0);
    check("rd3_rdata",   rsp_rdata,          32'hDEAD_BEEF);
    check("rd3_err",     32'(rsp_err),       32'd0);
    take_rsp();

    // Timeout: slave never acks
    slv_wait = -1; slv_rdata = 32'hCAFE_0001;
    e0 = enab_tot;
    send(1'b0, 32'h0000_0030, 32'h0, lat);
    check("tmo_latency", 32'(lat),           32'd9);
    check("tmo_enab",    32'(enab_tot - e0), 32'd8);
    check("tmo_err",     32'(rsp_err),       32'd1);
    check("tmo_rdata",   rsp_rdata,          32'h0);
    check("tmo_enaboff", 32'(apb_enab),      32'd0);
    take_rsp();

    // Next command after a timeout completes normally
    slv_wait = 0; slv_rdata = 32'h5555_AAAA;
    send(1'b0, 32'h0000_0040, 32'h0, lat);
    check("post_latency", 32'(lat),     32'd2);
    check("post_rdata",   rsp_rdata,    32'h5555_AAAA);
    check("post_err",     32'(rsp_err), 32'd0);
    take_rsp();

    // Response back-pressure with a second command waiting
    slv_wait = 0; slv_rdata = 32'h0BAD_F00D;
    send(1'b1, 32'h0000_0050, 32'h0000_0077, lat);
    check("bp_latency", 32'(lat), 32'd2);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h0000_0054; cmd_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_cready", 32'(cmd_ready), 32'd0);
      check("bp_rvalid", 32'(rsp_valid), 32'd1);
      check("bp_rdata",  rsp_rdata,      32'h0);
      check("bp_err",    32'(rsp_err),   32'd0);
      check("bp_psel",   32'(apb_psel),  32'd0);
      tick();
    end
    mon_addr  = 32'h0000_0054;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_h1_rvalid", 32'(rsp_valid), 32'd0);
    check("bp_h1_cready", 32'(cmd_ready), 32'd1);
    check("bp_h1_psel",   32'(apb_psel),  32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp_h2_psel",   32'(apb_psel),  32'd1);
    check("bp_h2_enab",   32'(apb_enab),  32'd0);
    check("bp_h2_addr",   apb_addr,       32'h0000_0054);
    wait_rsp(lat);
    check("bp2_latency",  32'(lat),       32'd2);
    check("bp2_rdata",    rsp_rdata,      32'h0BAD_F00D);
    take_rsp();

    // Ack in the very cycle the timeout would fire: normal completion wins
    slv_wait = TO - 1; slv_rdata = 32'h600D_0004;
    send(1'b0, 32'h0000_0058, 32'h0, lat);
    check("tie_latency", 32'(lat),     32'd9);
    check("tie_err",     32'(rsp_err), 32'd0);
    check("tie_rdata",   rsp_rdata,    32'h600D_0004);
    take_rsp();

    // Reset asserted during an ACCESS wait state
    slv_wait = -1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h0000_0060; mon_addr = 32'h0000_0060;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_enab_pre", 32'(apb_enab), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_psel",   32'(apb_psel),  32'd0);
    check("mid_enab",   32'(apb_enab),  32'd0);
    check("mid_rvalid", 32'(rsp_valid), 32'd0);
    tick();
    resetn = 1'b1;
    check("mid_cready", 32'(cmd_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || apb_psel !== 1'b0) stale++;
    end
    check("mid_stale", 32'(stale), 32'd0);

    // Recovery transfer after reset
    slv_wait = 1; slv_rdata = 32'hA5A5_5A5A;
    send(1'b0, 32'h0000_0070, 32'h0, lat);
    check("rec_latency", 32'(lat),     32'd3);
    check("rec_rdata",   rsp_rdata,    32'hA5A5_5A5A);
    check("rec_err",     32'(rsp_err), 32'd0);
    take_rsp();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
